// File: rtl/ahb_lite_sram_slave_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and the transfer address check.
// Used by the SRAM slave and its sub-modules.
package ahb_lite_sram_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Misaligned byte offset or word index past the end of the array.
    function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_sram.sv
// Word-wide 1R1W storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module ahb_lite_sram_slave_sram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave fronting a word SRAM: OKAY data phase is WAIT_STATES+1 cycles, ERROR is 2.
// Stalls the bus with HREADYOUT low during wait states and the first ERROR cycle.
module ahb_lite_sram_slave
    import ahb_lite_sram_slave_pkg::*;
#(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int         AW     = $clog2(MEM_DEPTH);
    localparam logic [3:0] W_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_idx;
    logic          r_write;
    logic [3:0]    r_wcnt;
    logic          w_accept;
    logic          w_err;
    logic          w_take;
    logic          w_mem_we;
    logic [31:0]   w_rdata;

    assign w_accept = HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    assign w_err    = addr_err(HADDR, 32'(MEM_DEPTH));
    // Only completing/idle cycles may open a new data phase.
    assign w_take   = w_accept && ((r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_wcnt  <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_take && !w_err) begin
                r_idx   <= HADDR[AW+1:2];
                r_write <= HWRITE;
            end
            if (w_take && !w_err && (WAIT_STATES > 0)) begin
                r_wcnt <= W_LOAD;
            end else if ((r_state == ST_WAIT) && (r_wcnt != 4'd0)) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (!w_take)                w_next = ST_IDLE;
                else if (w_err)             w_next = ST_ERR1;
                else if (WAIT_STATES > 0)   w_next = ST_WAIT;
                else                        w_next = ST_DATA;
            end
            ST_WAIT: w_next = (r_wcnt == 4'd0) ? ST_DATA : ST_WAIT;
            ST_ERR1: w_next = ST_ERR2;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = 32'd0;
        w_mem_we  = 1'b0;
        case (r_state)
            ST_WAIT: HREADYOUT = 1'b0;
            ST_DATA: begin
                w_mem_we = r_write;
                if (!r_write) HRDATA = w_rdata;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    ahb_lite_sram_slave_sram #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_sram (
        .i_clk   (HCLK),
        .i_we    (w_mem_we),
        .i_waddr (r_idx),
        .i_wdata (HWDATA),
        .i_raddr (r_idx),
        .o_rdata (w_rdata)
    );

endmodule
